axi_master_arbiter: RTL



---
 rtl/axi_master_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one line-wide master between a CPU cache port and a packed DMA write stream.
// Grant to strobe is 1 cycle, completion to done is 1 cycle; DMA is backpressured while its line buffer is full.
module axi_master_arbiter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int DATA_WIDTH_CACHE = 128,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cpu_req_i,
    input  logic                        cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]       cpu_addr_i,
    input  logic [DATA_WIDTH_CACHE-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH_CACHE-1:0] cpu_rdata_o,
    output logic                        cpu_done_o,
    output logic                        cpu_err_o,
    input  logic                        dma_wvalid_i,
    output logic                        dma_wready_o,
    input  logic [ADDR_WIDTH-1:0]       dma_addr_i,
    input  logic [DATA_WIDTH-1:0]       dma_wdata_i,
    output logic                        dma_done_o,
    output logic                        dma_err_o,
    output logic                        m_cs_o,
    output logic                        m_we_o,
    output logic [ADDR_WIDTH-1:0]       m_addr_o,
    output logic [DATA_WIDTH_CACHE-1:0] m_wdata_o,
    input  logic [DATA_WIDTH_CACHE-1:0] m_rdata_i,
    input  logic                        m_rvalid_i,
    input  logic                        m_bdone_i,
    output logic                        busy_o
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                      state, state_nxt;
    logic                        last_dma, grant_dma, err_flag;
    logic [1:0]                  fill;
    logic                        full;
    logic [DATA_WIDTH_CACHE-1:0] line_buf;
    logic [ADDR_WIDTH-1:0]       line_addr;
    logic [WD_W-1:0]             wdog;
    logic                        grant, pick_dma, done, timeout, accept;

    // Only the completion matching the issued direction counts.
    assign done         = m_we_o ? m_bdone_i : m_rvalid_i;
    assign timeout      = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign dma_wready_o = !full && !rst_i;
    assign accept       = dma_wvalid_i && dma_wready_o;

    assign m_cs_o     = (state == ISSUE);
    assign busy_o     = (state != IDLE);
    assign cpu_done_o = (state == GAP) && !grant_dma;
    assign dma_done_o = (state == GAP) && grant_dma;
    assign cpu_err_o  = cpu_done_o && err_flag;
    assign dma_err_o  = dma_done_o && err_flag;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        pick_dma  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req_i || full) begin
                    grant     = 1'b1;
                    pick_dma  = full && (!cpu_req_i || !last_dma);
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done || timeout) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_dma    <= 1'b1;
            grant_dma   <= 1'b0;
            err_flag    <= 1'b0;
            fill        <= '0;
            full        <= 1'b0;
            line_buf    <= '0;
            line_addr   <= '0;
            wdog        <= '0;
            m_we_o      <= 1'b0;
            m_addr_o    <= '0;
            m_wdata_o   <= '0;
            cpu_rdata_o <= '0;
        end else begin
            if (accept) begin
                line_buf[DATA_WIDTH*int'(fill) +: DATA_WIDTH] <= dma_wdata_i;
                if (fill == 2'd0) line_addr <= dma_addr_i;
                if (fill == 2'd3) full <= 1'b1;
                fill <= fill + 2'd1;
            end
            if (grant) begin
                grant_dma <= pick_dma;
                err_flag  <= 1'b0;
                m_we_o    <= pick_dma || cpu_we_i;
                m_addr_o  <= pick_dma ? line_addr : cpu_addr_i;
                m_wdata_o <= pick_dma ? line_buf : cpu_wdata_i;
            end
            if (state == WAIT) begin
                wdog <= wdog + WD_W'(1);
                if (!done && timeout) err_flag <= 1'b1;
                if (done && !grant_dma && !m_we_o) cpu_rdata_o <= m_rdata_i;
            end
            // A DMA grant frees the buffer whether it succeeded or timed out.
            if (state == GAP) begin
                wdog     <= '0;
                last_dma <= grant_dma;
                if (grant_dma) begin
                    full <= 1'b0;
                    fill <= '0;
                end
            end
        end
    end
endmodule
